// File: rtl/ballot_pkg.sv
// ballot_pkg: shared state/choice encodings and default timing constants for the ballot front-end
package ballot_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HOLDOFF, ST_REJECT} state_t;
  localparam logic [1:0] CHOICE_A = 2'b00;
  localparam logic [1:0] CHOICE_B = 2'b01;
  localparam logic [1:0] CHOICE_C = 2'b10;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLDOFF_CYCLES = 8;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises one raw button and debounces it; the level resets to pressed
module button_debouncer
  import ballot_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sr;
  logic [CW-1:0] cnt;
  logic sync, flip;
  assign sync = sr[SYNC_STAGES-1];
  assign flip = (sync != db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      db  <= 1'b1;
    end else begin
      sr  <= {sr[SYNC_STAGES-2:0], raw};
      cnt <= (sync == db || flip) ? '0 : cnt + 1'b1;
      db  <= flip ? sync : db;
    end
  end
endmodule

// File: rtl/ballot_input_conditioner.sv
// ballot_input_conditioner: accepts one clean single-button vote per card and holds it until release.
// Define BALLOT_REJECT_COUNT_EN to add a saturating reject_count output.
module ballot_input_conditioner
  import ballot_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_a_raw,
  input  logic       btn_b_raw,
  input  logic       btn_c_raw,
  input  logic       card_present_raw,
  input  logic [3:0] voter_id_raw,
  output logic       vote_a,
  output logic       vote_b,
  output logic       vote_c,
  output logic [3:0] voter_id,
  output logic       ready,
`ifdef BALLOT_REJECT_COUNT_EN
  output logic       multi_press,
  output logic [7:0] reject_count
`else
  output logic       multi_press
`endif
);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [2:0] db;
  logic [SYNC_STAGES-1:0] card_sr;
  logic [3:0] id_sr [SYNC_STAGES];
  logic card_sync, pulse;
  state_t state, next;
  logic [1:0] choice, choice_n;
  logic [HW-1:0] hcnt;
  button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_db_a (.clk(clk), .reset(reset), .raw(btn_a_raw), .db(db[0]));
  button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_db_b (.clk(clk), .reset(reset), .raw(btn_b_raw), .db(db[1]));
  button_debouncer #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_db_c (.clk(clk), .reset(reset), .raw(btn_c_raw), .db(db[2]));
  assign card_sync = card_sr[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      card_sr <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) id_sr[i] <= '0;
    end else begin
      card_sr  <= {card_sr[SYNC_STAGES-2:0], card_present_raw};
      id_sr[0] <= voter_id_raw;
      for (int i = 1; i < SYNC_STAGES; i++) id_sr[i] <= id_sr[i-1];
    end
  end
  always_comb begin
    next     = state;
    choice_n = choice;
    pulse    = 1'b0;
    case (state)
      ST_IDLE:
        if ($onehot(db) && card_sync) begin
          next     = ST_PRESS;
          choice_n = db[0] ? CHOICE_A : (db[1] ? CHOICE_B : CHOICE_C);
        end else if (|db) begin
          next  = ST_REJECT;
          pulse = 1'b1;
        end
      ST_PRESS:   next = |db ? ST_PRESS : ST_HOLDOFF;
      ST_HOLDOFF: next = (hcnt != '0) ? ST_HOLDOFF : (|db ? ST_REJECT : ST_IDLE);
      default:    next = |db ? ST_REJECT : ST_IDLE;
    endcase
  end
  // outputs are registered from next so they change on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_REJECT;
      choice      <= CHOICE_A;
      hcnt        <= '0;
      voter_id    <= '0;
      vote_a      <= 1'b0;
      vote_b      <= 1'b0;
      vote_c      <= 1'b0;
      ready       <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      state       <= next;
      choice      <= choice_n;
      hcnt        <= (state != ST_HOLDOFF) ? HW'(HOLDOFF_CYCLES - 1) : hcnt - HW'(hcnt != '0);
      voter_id    <= (state == ST_IDLE && next == ST_PRESS) ? id_sr[SYNC_STAGES-1] : voter_id;
      vote_a      <= next == ST_PRESS && choice_n == CHOICE_A;
      vote_b      <= next == ST_PRESS && choice_n == CHOICE_B;
      vote_c      <= next == ST_PRESS && choice_n == CHOICE_C;
      ready       <= next == ST_IDLE;
      multi_press <= pulse;
    end
  end
`ifdef BALLOT_REJECT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) reject_count <= '0;
    else reject_count <= (pulse && reject_count != 8'hff) ? reject_count + 1'b1 : reject_count;
  end
`endif
endmodule

// File: doc/ballot_input_conditioner.md
Name: ballot_input_conditioner

Overview:
- Front-end stage directly upstream of the vote-counting FSM; sits between raw booth push-buttons / ID-card reader and the counter's vote_a/b/c and voter_id inputs.
- Synchronises and debounces three candidate buttons.
- Accepts exactly one clean single-button press per card presence and holds a one-hot vote level until full release, so the counter's lock/release logic sees glitch-free levels.
- Rejects multi-button presses and presses without a card, then enforces a hold-off before re-arming.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per raw input (min 2)
- DEBOUNCE_CYCLES, 16, consecutive disagreeing cycles required to change a debounced level (min 2)
- HOLDOFF_CYCLES, 8, dead time after release before the next press is accepted (min 1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_a_raw  in  1  candidate A button, asynchronous, active-high
- btn_b_raw  in  1  candidate B button
- btn_c_raw  in  1  candidate C button
- card_present_raw  in  1  voter card inserted, asynchronous
- voter_id_raw  in  4  card ID, asynchronous, stable while card present
- vote_a  out  1  clean vote level for A
- vote_b  out  1  clean vote level for B
- vote_c  out  1  clean vote level for C
- voter_id  out  4  ID latched at press acceptance
- ready  out  1  high in IDLE only
- multi_press  out  1  one-cycle pulse on rejected press

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Synchronisation:
  - All raw inputs pass through SYNC_STAGES flops, reset 0.
  - voter_id_raw is synchronised but not debounced.
- Debounce, per button:
  - Holds a stable level db and a counter.
  - Counter increments while sync != db and clears when sync == db.
  - On the DEBOUNCE_CYCLES-th consecutive disagreeing edge, db <= sync and the counter clears.
  - db resets to 1 (assumed pressed), so buttons held across reset are never counted.
- FSM states: IDLE, PRESS, HOLDOFF, REJECT. Reset state is REJECT; no multi_press pulse is generated on reset entry.
- IDLE:
  - Exactly one db high and card_present_sync high -> PRESS. Latch choice (00=A, 01=B, 10=C) and voter_id <= synchronised ID.
  - Two or more db high, or one db high with no card -> REJECT, with a multi_press pulse in the transition cycle.
  - All db low -> stay in IDLE.
- PRESS:
  - The vote output for the latched choice is high; the others are low.
  - Extra buttons pressed are ignored; the output is unchanged.
  - Card removal is ignored.
  - All db low -> HOLDOFF.
- HOLDOFF:
  - Outputs low; the counter loads HOLDOFF_CYCLES-1 on entry.
  - At 0: all db low -> IDLE, else -> REJECT (no pulse).
- REJECT: outputs low; wait until all db are low -> IDLE.
- Output timing:
  - Outputs are registered from next-state, so vote_x rises on the same edge the state becomes PRESS.
  - Raw rise to vote_x rise = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
  - Raw fall to vote_x fall is the same latency.
- voter_id holds until the next accepted press.
- Reset values: vote_a/b/c = 0, voter_id = 0, ready = 0, multi_press = 0.
- Asynchronous reset mid-press drops vote_x immediately.

Optional Feature:
- Macro: BALLOT_REJECT_COUNT_EN.
- Defined:
  - Adds output reject_count[7:0], reset 0.
  - Increments on every multi_press pulse and saturates at 255.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- ballot_pkg holds:
  - FSM state encoding
  - Choice encoding constants CHOICE_A=2'b00, CHOICE_B=2'b01, CHOICE_C=2'b10, shared with the vote counter
  - Default parameter constants
- One sub-module: button_debouncer (synchroniser + debounce counter, parameterised), instantiated three times.
- Card and ID synchronisers are inline.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8):
1. Reset with btn_a_raw held high -> all outputs 0. After reset release, vote_a stays 0. ready rises 7 edges after btn_a_raw falls (db settles, then REJECT -> IDLE).
2. Card present, voter_id_raw=5, btn_b_raw high for 20 cycles then low:
   - vote_b rises 7 edges after the raw rise; voter_id=5.
   - vote_b falls 7 edges after the raw fall.
   - ready rises 8 edges after vote_b falls.
3. btn_a_raw pulses high for 3 cycles, low 1, high 3, low -> vote_a never asserts; ready stays 1.
4. btn_a_raw and btn_c_raw rise together -> no vote output; a single multi_press pulse 7 edges later. ready returns only after both are released and debounced.
5. Card absent, btn_c_raw held -> multi_press pulse, no vote; with BALLOT_REJECT_COUNT_EN, reject_count=1.
6. During HOLDOFF, re-press btn_a and keep it held -> no vote; REJECT entered at hold-off end. Release -> IDLE. A fresh press then yields vote_a.
